// File: rtl/jtdsp16_docache.sv
// Loop-body cache for the DSP16 do/redo construct: captures the body from ROM
// on the first pass and replays it while the program counter is held.
module jtdsp16_docache #(
  parameter int DEPTH = 15,
  parameter int KW    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        inst_adv,
  input  logic [15:0] rom_dout,
  output logic [15:0] cache_dout,
  output logic        cache_sel,
  output logic        pc_hold,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    LOOP = 2'd2
  } state_t;

  localparam logic [3:0]    DEPTH_W = 4'(DEPTH);
  localparam logic [KW-1:0] K_ONE   = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] K_ZERO  = {KW{1'b0}};

  state_t        state_r, state_s;
  logic [3:0]    idx_r, idx_s;
  logic [3:0]    ni_r, ni_s;
  logic [KW-1:0] kcnt_r, kcnt_s;
  logic          valid_r, valid_s;
  logic          fault_r, fault_s;
  logic          wr_en_s;
  logic          busy_r, cache_sel_r, pc_hold_r;
  logic [15:0]   mem_r [DEPTH];

  logic [3:0]    cmd_ni_s;
  logic [KW-1:0] cmd_k_s;
  logic          last_s;
  logic          kone_s;

  assign cmd_ni_s = do_data[10:7];
  assign cmd_k_s  = do_data[KW-1:0];
  assign last_s   = (idx_r == (ni_r - 4'd1));
  assign kone_s   = (kcnt_r == K_ONE);

  // Next-state, counter and fault logic; nothing moves unless cen is high
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    ni_s    = ni_r;
    kcnt_s  = kcnt_r;
    valid_s = valid_r;
    fault_s = fault_r;
    wr_en_s = 1'b0;
    if (cen) begin
      case (state_r)
        IDLE: begin
          if (do_start) begin
            if ((cmd_k_s == K_ZERO) || (cmd_ni_s > DEPTH_W)) begin
              fault_s = 1'b1;
            end else if (cmd_ni_s != 4'd0) begin
              ni_s    = cmd_ni_s;
              kcnt_s  = cmd_k_s;
              idx_s   = 4'd0;
              valid_s = 1'b0;
              state_s = FILL;
            end else if (valid_r) begin
              kcnt_s  = cmd_k_s;
              idx_s   = 4'd0;
              state_s = LOOP;
            end else begin
              fault_s = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        FILL: begin
          // A nested do is flagged but does not disturb the running loop
          if (do_start) begin
            fault_s = 1'b1;
          end else begin
            fault_s = fault_r;
          end
          if (inst_adv) begin
            wr_en_s = 1'b1;
            if (last_s) begin
              idx_s   = 4'd0;
              valid_s = 1'b1;
              kcnt_s  = kcnt_r - K_ONE;
              state_s = kone_s ? IDLE : LOOP;
            end else begin
              idx_s = idx_r + 4'd1;
            end
          end else begin
            wr_en_s = 1'b0;
          end
        end
        LOOP: begin
          if (do_start) begin
            fault_s = 1'b1;
          end else begin
            fault_s = fault_r;
          end
          if (inst_adv) begin
            if (last_s) begin
              idx_s   = 4'd0;
              kcnt_s  = kcnt_r - K_ONE;
              state_s = kone_s ? IDLE : LOOP;
            end else begin
              idx_s = idx_r + 4'd1;
            end
          end else begin
            idx_s = idx_r;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = 4'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Control state and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 4'd0;
      ni_r        <= 4'd0;
      kcnt_r      <= K_ZERO;
      valid_r     <= 1'b0;
      fault_r     <= 1'b0;
      busy_r      <= 1'b0;
      cache_sel_r <= 1'b0;
      pc_hold_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      ni_r        <= ni_s;
      kcnt_r      <= kcnt_s;
      valid_r     <= valid_s;
      fault_r     <= fault_s;
      busy_r      <= (state_s != IDLE);
      cache_sel_r <= (state_s == LOOP);
      pc_hold_r   <= (state_s == LOOP);
    end
  end

  // Body storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[idx_r] <= rom_dout;
    end
  end

  assign cache_dout = cache_sel_r ? mem_r[idx_r] : 16'h0000;
  assign cache_sel  = cache_sel_r;
  assign pc_hold    = pc_hold_r;
  assign busy       = busy_r;
  assign fault      = fault_r;

endmodule
